pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the CPU fetch stage.
- Generates the fetch address, with a valid/ready handshake to instruction memory.
- Redirects raised while fetch is stalled are buffered, not lost.
- Adds exception entry/return (EPC) and configurable reset/exception vectors; sits between the control unit/branch compare and the instruction memory port.

Parameters:
- ADDR_W, 32, PC width; legal range 28..32.
- RESET_VEC, 32'h0000_0000, PC after reset (low ADDR_W bits used).
- EXC_VEC, 32'h0000_0180, exception entry address.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low.
- pc_control  in  3  000 SEQ, 001 J, 010 JR, 011 BR, 100 ERET, 101-111 treated as SEQ.
- jmp_addr  in  26  J instruction index.
- branch_offset  in  16  BR word offset, signed.
- branch_taken  in  1  BR condition result; BR with 0 behaves as SEQ.
- reg_addr  in  ADDR_W  JR target.
- exc_req  in  1  exception request, one-cycle pulse.
- fetch_ready  in  1  instruction memory accepts pc this cycle.
- fetch_valid  out  1  pc is a valid fetch address.
- pc  out  ADDR_W  current fetch address.
- epc  out  ADDR_W  saved exception PC.
- jr_misalign  out  1  one-cycle pulse: JR target had nonzero bits [1:0].

Behaviour:
- Reset (rst=0 at edge):
  - pc=RESET_VEC, epc=0, fetch_valid=0, jr_misalign=0.
  - Pending buffer cleared; state=BOOT.
- States:
  - BOOT: fetch_valid=0; unconditionally -> RUN next cycle; pc unchanged.
  - RUN: fetch_valid=1, no pending redirect.
  - HOLD: fetch_valid=1, redirect pending.
- Widths and targets:
  - seq_pc = pc+4, modulo 2^ADDR_W (wraps from all-ones-minus-3 to 0).
  - J target = {seq_pc[ADDR_W-1:28], jmp_addr, 2'b00}.
  - BR target = seq_pc + sign-extend({branch_offset, 2'b00}) to ADDR_W, modulo.
  - JR target = {reg_addr[ADDR_W-1:2], 2'b00}; jr_misalign pulses the cycle after JR is sampled with reg_addr[1:0]!=0.
  - ERET target = epc.
- Advance: pc changes only on an edge with fetch_ready=1 and state RUN/HOLD ("accept"), except for exceptions.
- RUN:
  - accept, redirect -> pc=target.
  - accept, no redirect -> pc=seq_pc.
  - no accept, redirect -> target latched into pend_q, -> HOLD, pc held.
- HOLD:
  - accept -> pc=pend_q, -> RUN.
  - A new redirect in the same cycle overrides pend_q: pc=new target.
  - New redirect without accept overwrites pend_q (newest wins).
- Controls (pc_control, branch_taken) are sampled every cycle in RUN/HOLD; ignored in BOOT.
- exc_req (highest priority, any state except BOOT, regardless of fetch_ready):
  - epc=pc, pc=EXC_VEC, pend_q discarded, -> RUN.
  - If exc_req and a redirect arrive in the same cycle: exception wins, redirect dropped.
- Reset mid-HOLD discards pend_q.
- Latency: redirect visible on pc one cycle after sampling when fetch_ready=1.

Optional Feature:
- Macro: PC_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - An accepted J/JR/BR-taken/ERET sets pc=seq_pc and stores the target in pend_q (-> HOLD).
  - The next accept loads the target.
  - A redirect arriving while the delay-slot target is pending is ignored.
  - exc_req clears the pending target.
- Undefined: redirect applies immediately as above.

Decomposition:
- Shared package cpu_pkg:
  - pc_control encodings as named constants (PC_SEQ, PC_J, PC_JR, PC_BR, PC_ERET).
  - State encoding (BOOT/RUN/HOLD).
  - Default vectors.
- One natural sub-module: pc_target_calc, purely combinational (seq_pc and the four targets, misalign flag). The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then free-run, fetch_ready=1: fetch_valid=0 one cycle, then pc 0,4,8,C.
- pc=0x100, BR taken, offset 16'hFFFE, ready=1 -> pc=0x0FC. Same with branch_taken=0 -> 0x104.
- pc=0x4000_0010, J jmp_addr=26'h0000040 -> pc=0x4000_0100. Then JR reg_addr=0x203 -> pc=0x200 and jr_misalign pulse.
- fetch_ready=0, J to 0x80, next cycle J to 0xC0, then ready=1 -> pc stays during stall, then pc=0xC0.
- pc=0x500, exc_req with fetch_ready=0 and concurrent BR -> pc=EXC_VEC, epc=0x500. ERET later -> pc=0x500.
- PC_DELAY_SLOT_EN, pc=0x20, J to 0x80 -> pc=0x24, then 0x80. Run the same directed test without the macro -> 0x80 directly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-stage program counter: pc_control encodings,
// sequencer state encoding and default reset/exception vectors.
package cpu_pkg;

    localparam logic [2:0] PC_SEQ  = 3'b000;
    localparam logic [2:0] PC_J    = 3'b001;
    localparam logic [2:0] PC_JR   = 3'b010;
    localparam logic [2:0] PC_BR   = 3'b011;
    localparam logic [2:0] PC_ERET = 3'b100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

    // Encodings 101-111 fall through to sequential fetch.
    function automatic logic is_redirect(input logic [2:0] ctrl, input logic taken);
        case (ctrl)
            PC_J, PC_JR, PC_ERET: is_redirect = 1'b1;
            PC_BR:                is_redirect = taken;
            default:              is_redirect = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-address logic: sequential pc, J/JR/BR/ERET targets,
// selected redirect target and the JR misalignment flag.
module pc_target_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] epc,
    input  logic [2:0]        pc_control,
    input  logic [25:0]       jmp_addr,
    input  logic [15:0]       branch_offset,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] reg_addr,
    output logic [ADDR_W-1:0] seq_pc,
    output logic [ADDR_W-1:0] target,
    output logic              redirect,
    output logic              jr_misalign_flag
);

    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] br_off_ext;

    assign seq_pc = pc + ADDR_W'(4);

    // A 28-bit pc has no upper region bits to carry over into a J target.
    generate
        if (ADDR_W > 28) begin : g_j_region
            assign j_target = {seq_pc[ADDR_W-1:28], jmp_addr, 2'b00};
        end else begin : g_j_flat
            assign j_target = {jmp_addr, 2'b00};
        end
    endgenerate

    assign br_off_ext = {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign br_target  = seq_pc + br_off_ext;
    assign jr_target  = {reg_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        target           = seq_pc;
        redirect         = is_redirect(pc_control, branch_taken);
        jr_misalign_flag = 1'b0;
        case (pc_control)
            PC_J:    target = j_target;
            PC_JR: begin
                target           = jr_target;
                jr_misalign_flag = (reg_addr[1:0] != 2'b00);
            end
            PC_BR:   target = branch_taken ? br_target : seq_pc;
            PC_ERET: target = epc;
            default: target = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with valid/ready handshake, buffered redirects,
// exception entry/return. Define PC_DELAY_SLOT_EN for MIPS branch delay slots.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        pc_control,
    input  logic [25:0]       jmp_addr,
    input  logic [15:0]       branch_offset,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              exc_req,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] epc,
    output logic              jr_misalign
);

    // state   | meaning
    // BOOT    | first cycle after reset, no fetch presented
    // RUN     | fetching, nothing pending
    // HOLD    | fetching, redirect (or delay-slot target) waiting in pend_q

    localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              mis_q, mis_d;
`ifdef PC_DELAY_SLOT_EN
    logic              ds_q, ds_d;
`endif

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] target;
    logic              redirect;
    logic              jr_mis_flag;
    logic              accept;

    pc_target_calc #(
        .ADDR_W(ADDR_W)
    ) u_target_calc (
        .pc               (pc_q),
        .epc              (epc_q),
        .pc_control       (pc_control),
        .jmp_addr         (jmp_addr),
        .branch_offset    (branch_offset),
        .branch_taken     (branch_taken),
        .reg_addr         (reg_addr),
        .seq_pc           (seq_pc),
        .target           (target),
        .redirect         (redirect),
        .jr_misalign_flag (jr_mis_flag)
    );

    assign accept = fetch_ready && (state_q != ST_BOOT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        pend_d  = pend_q;
        mis_d   = 1'b0;
`ifdef PC_DELAY_SLOT_EN
        ds_d    = ds_q;
`endif
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_HOLD: begin
                mis_d = jr_mis_flag;
                if (exc_req) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_PC;
                    pend_d  = '0;
                    state_d = ST_RUN;
`ifdef PC_DELAY_SLOT_EN
                    ds_d    = 1'b0;
`endif
                end else if (state_q == ST_RUN) begin
`ifdef PC_DELAY_SLOT_EN
                    if (accept && redirect) begin
                        // Delay slot: fetch pc+4 first, target goes next.
                        pc_d    = seq_pc;
                        pend_d  = target;
                        ds_d    = 1'b1;
                        state_d = ST_HOLD;
                    end else if (accept) begin
                        pc_d = seq_pc;
                    end else if (redirect) begin
                        pend_d  = target;
                        ds_d    = 1'b0;
                        state_d = ST_HOLD;
                    end
`else
                    if (accept) begin
                        pc_d = redirect ? target : seq_pc;
                    end else if (redirect) begin
                        pend_d  = target;
                        state_d = ST_HOLD;
                    end
`endif
                end else begin
`ifdef PC_DELAY_SLOT_EN
                    if (ds_q) begin
                        if (accept) begin
                            pc_d    = pend_q;
                            ds_d    = 1'b0;
                            state_d = ST_RUN;
                        end
                    end else if (accept) begin
                        // Stalled redirect now accepted: it still owes a delay slot.
                        pc_d   = seq_pc;
                        pend_d = redirect ? target : pend_q;
                        ds_d   = 1'b1;
                    end else if (redirect) begin
                        pend_d = target;
                    end
`else
                    if (accept) begin
                        pc_d    = redirect ? target : pend_q;
                        state_d = ST_RUN;
                    end else if (redirect) begin
                        pend_d = target;
                    end
`endif
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RST_PC;
            epc_q   <= '0;
            pend_q  <= '0;
            mis_q   <= 1'b0;
`ifdef PC_DELAY_SLOT_EN
            ds_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            pend_q  <= pend_d;
            mis_q   <= mis_d;
`ifdef PC_DELAY_SLOT_EN
            ds_q    <= ds_d;
`endif
        end
    end

    assign fetch_valid = (state_q != ST_BOOT);
    assign pc          = pc_q;
    assign epc         = epc_q;
    assign jr_misalign = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected outputs,
// a monitor pops and compares them after every clock edge.
module tb_pc_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pc_control;
    logic [25:0] jmp_addr;
    logic [15:0] branch_offset;
    logic        branch_taken;
    logic [31:0] reg_addr;
    logic        exc_req;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        jr_misalign;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_epc = 32'h0;

    pc_sequencer #(
        .ADDR_W   (32),
        .RESET_VEC(32'h0000_0000),
        .EXC_VEC  (32'h0000_0180)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_control   (pc_control),
        .jmp_addr     (jmp_addr),
        .branch_offset(branch_offset),
        .branch_taken (branch_taken),
        .reg_addr     (reg_addr),
        .exc_req      (exc_req),
        .fetch_ready  (fetch_ready),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .epc          (epc),
        .jr_misalign  (jr_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.valid});
                chk("pc", pc, e.pc);
                chk("epc", epc, e.epc);
                chk("jr_misalign", {31'b0, jr_misalign}, {31'b0, e.mis});
            end
        end
    end

    task automatic step(input logic r, input logic [2:0] ctrl, input logic [25:0] j,
                        input logic [15:0] off, input logic tk, input logic [31:0] ra,
                        input logic ex, input logic rdy,
                        input logic [31:0] e_pc, input logic e_valid, input logic e_mis);
        exp_t e;
        @(negedge clk);
        rst = r; pc_control = ctrl; jmp_addr = j; branch_offset = off;
        branch_taken = tk; reg_addr = ra; exc_req = ex; fetch_ready = rdy;
        e.pc = e_pc; e.epc = exp_epc; e.valid = e_valid; e.mis = e_mis;
        exp_q.push_back(e);
    endtask

    task automatic seq(input logic [31:0] e_pc);
        step(1, PC_SEQ, 26'h0, 16'h0, 0, 32'h0, 0, 1, e_pc, 1, 0);
    endtask

    // Accepted redirect: immediate, or pc+4 first then the target with delay slots.
    task automatic redir(input logic [2:0] ctrl, input logic [25:0] j, input logic [15:0] off,
                         input logic tk, input logic [31:0] ra,
                         input logic [31:0] seq_exp, input logic [31:0] tgt_exp, input logic mis);
`ifdef PC_DELAY_SLOT_EN
        step(1, ctrl, j, off, tk, ra, 0, 1, seq_exp, 1, mis);
        seq(tgt_exp);
`else
        step(1, ctrl, j, off, tk, ra, 0, 1, tgt_exp, 1, mis);
`endif
    endtask

    task automatic go_to(input logic [31:0] cur, input logic [31:0] addr);
        redir(PC_JR, 26'h0, 16'h0, 0, addr, cur + 32'd4, addr, 0);
    endtask

    initial begin
        rst = 0; pc_control = PC_SEQ; jmp_addr = 0; branch_offset = 0;
        branch_taken = 0; reg_addr = 0; exc_req = 0; fetch_ready = 1;

        // reset, BOOT cycle, free run
        step(0, PC_SEQ, 26'h0, 16'h0, 0, 32'h0, 0, 1, 32'h0, 0, 0);
        step(1, PC_SEQ, 26'h0, 16'h0, 0, 32'h0, 0, 1, 32'h0, 1, 0);
        seq(32'h4);
        seq(32'h8);
        seq(32'hC);

        // branch taken backwards, then not taken
        go_to(32'hC, 32'h100);
        redir(PC_BR, 26'h0, 16'hFFFE, 1, 32'h0, 32'h104, 32'h0FC, 0);
        go_to(32'h0FC, 32'h100);
        step(1, PC_BR, 26'h0, 16'hFFFE, 0, 32'h0, 0, 1, 32'h104, 1, 0);

        // J keeps region bits, JR misaligned
        go_to(32'h104, 32'h4000_0010);
        redir(PC_J, 26'h0000040, 16'h0, 0, 32'h0, 32'h4000_0014, 32'h4000_0100, 0);
        redir(PC_JR, 26'h0, 16'h0, 0, 32'h203, 32'h4000_0104, 32'h200, 1);

        // stalled redirects, newest wins
        step(1, PC_J, 26'h20, 16'h0, 0, 32'h0, 0, 0, 32'h200, 1, 0);
        step(1, PC_J, 26'h30, 16'h0, 0, 32'h0, 0, 0, 32'h200, 1, 0);
`ifdef PC_DELAY_SLOT_EN
        seq(32'h204);
`endif
        seq(32'hC0);

        // exception beats concurrent branch while stalled, then ERET
        go_to(32'hC0, 32'h500);
        exp_epc = 32'h500;
        step(1, PC_BR, 26'h0, 16'h0004, 1, 32'h0, 1, 0, 32'h180, 1, 0);
        seq(32'h184);
        redir(PC_ERET, 26'h0, 16'h0, 0, 32'h0, 32'h188, 32'h500, 0);

        // delay-slot scenario from 0x20
        go_to(32'h500, 32'h20);
        redir(PC_J, 26'h20, 16'h0, 0, 32'h0, 32'h24, 32'h80, 0);

        // exception in HOLD discards the pending redirect
        step(1, PC_J, 26'h30, 16'h0, 0, 32'h0, 0, 0, 32'h80, 1, 0);
        exp_epc = 32'h80;
        step(1, PC_SEQ, 26'h0, 16'h0, 0, 32'h0, 1, 0, 32'h180, 1, 0);
        seq(32'h184);

        // reset mid-HOLD discards the pending redirect
        step(1, PC_J, 26'h30, 16'h0, 0, 32'h0, 0, 0, 32'h184, 1, 0);
        exp_epc = 32'h0;
        step(0, PC_SEQ, 26'h0, 16'h0, 0, 32'h0, 0, 1, 32'h0, 0, 0);
        step(1, PC_SEQ, 26'h0, 16'h0, 0, 32'h0, 0, 1, 32'h0, 1, 0);
        seq(32'h4);

        // sequential wrap at top of address space
        go_to(32'h4, 32'hFFFF_FFFC);
        seq(32'h0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
